// File: rtl/branch_predictor_table.sv
// PC-indexed table of saturating direction counters with an init-sweep FSM and branch statistics.
// Optional gshare history indexing is enabled by defining BPT_GSHARE_EN.
module branch_predictor_table #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int INIT_CTR = 1,
  parameter int PC_WIDTH = 32,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PC_WIDTH-1:0] lookup_pc_i,
  output logic                predict_o,
  output logic [IDX_W-1:0]    lookup_idx_o,
  input  logic                update_i,
  input  logic [IDX_W-1:0]    update_idx_i,
  input  logic                result_i,
  input  logic                predicted_i,
  input  logic                clear_i,
  output logic                ready_o,
  output logic [31:0]         branch_cnt_o,
  output logic [31:0]         mispred_cnt_o
);

  localparam logic [CTR_BITS-1:0] INIT_V  = CTR_BITS'(INIT_CTR);
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   sweep_idx, sweep_nxt;
  logic [CTR_BITS-1:0] tbl [ENTRIES];
  logic [IDX_W-1:0]   pc_idx;

  // Only the word-index bits of the PC take part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[PC_WIDTH-1:IDX_W+2], lookup_pc_i[1:0]};
  assign pc_idx = lookup_pc_i[IDX_W+1:2];

`ifdef BPT_GSHARE_EN
  logic [IDX_W-1:0] ghr;
  logic [IDX_W:0]   ghr_shift;
  assign ghr_shift    = {ghr, result_i};
  assign lookup_idx_o = pc_idx ^ ghr;

  // History is non-speculative; clear wins over a same-cycle resolution.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        ghr <= '0;
    else if (clear_i)  ghr <= '0;
    else if (update_i) ghr <= ghr_shift[IDX_W-1:0];
  end
`else
  assign lookup_idx_o = pc_idx;
`endif

  assign ready_o   = (state == ST_RUN);
  assign predict_o = ready_o ? tbl[lookup_idx_o][CTR_BITS-1] : INIT_V[CTR_BITS-1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= ST_INIT;
      sweep_idx <= '0;
    end else begin
      state     <= state_nxt;
      sweep_idx <= sweep_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep_idx;
    if (clear_i) begin
      state_nxt = ST_INIT;
      sweep_nxt = '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (sweep_idx == IDX_W'(ENTRIES - 1)) begin
            state_nxt = ST_RUN;
            sweep_nxt = '0;
          end else begin
            sweep_nxt = sweep_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage has no reset; contents become valid only through the sweep.
  always_ff @(posedge clk_i) begin
    if (!clear_i) begin
      if (state == ST_INIT) begin
        tbl[sweep_idx] <= INIT_V;
      end else if (update_i) begin
        if (result_i && tbl[update_idx_i] != CTR_MAX)
          tbl[update_idx_i] <= tbl[update_idx_i] + 1'b1;
        else if (!result_i && tbl[update_idx_i] != '0)
          tbl[update_idx_i] <= tbl[update_idx_i] - 1'b1;
      end
    end
  end

  // Statistics count every resolution, including ones dropped during init.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (update_i) begin
      branch_cnt_o <= branch_cnt_o + 32'd1;
      if (predicted_i != result_i) mispred_cnt_o <= mispred_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
// Randomised and directed checks of branch_predictor_table against a behavioural table model.
module tb_branch_predictor_table;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] lookup_pc_i = '0;
  logic        predict_o;
  logic [3:0]  lookup_idx_o;
  logic        update_i = 1'b0;
  logic [3:0]  update_idx_i = '0;
  logic        result_i = 1'b0;
  logic        predicted_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        ready_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  branch_predictor_table dut (
    .clk_i(clk), .rst_i(rst_i), .lookup_pc_i(lookup_pc_i), .predict_o(predict_o),
    .lookup_idx_o(lookup_idx_o), .update_i(update_i), .update_idx_i(update_idx_i),
    .result_i(result_i), .predicted_i(predicted_i), .clear_i(clear_i), .ready_o(ready_o),
    .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  // Reference model: counter values as plain integers, init as a remaining-cycle count.
  int unsigned m_ctr [16];
  int          m_rem;
  int unsigned m_br, m_mis;
  logic [3:0]  m_ghr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    m_rem = 16; m_br = 0; m_mis = 0; m_ghr = '0;
  endtask

  task automatic model_edge();
    if (update_i) begin
      m_br++;
      if (predicted_i != result_i) m_mis++;
`ifdef BPT_GSHARE_EN
      m_ghr = {m_ghr[2:0], result_i};
`endif
    end
    if (clear_i) begin
      for (int i = 0; i < 16; i++) m_ctr[i] = 1;
      m_rem = 16; m_ghr = '0;
    end else if (m_rem > 0) begin
      m_rem--;
    end else if (update_i) begin
      if (result_i && m_ctr[update_idx_i] < 3) m_ctr[update_idx_i]++;
      if (!result_i && m_ctr[update_idx_i] > 0) m_ctr[update_idx_i]--;
    end
  endtask

  task automatic check_outs();
    logic [3:0] idx;
    idx = lookup_pc_i[5:2] ^ m_ghr;
    chk("idx", 32'(lookup_idx_o), 32'(idx));
    chk("ready", 32'(ready_o), (m_rem == 0) ? 32'd1 : 32'd0);
    chk("predict", 32'(predict_o), (m_rem == 0 && m_ctr[idx] >= 2) ? 32'd1 : 32'd0);
    chk("branch_cnt", branch_cnt_o, m_br);
    chk("mispred_cnt", mispred_cnt_o, m_mis);
  endtask

  task automatic step(input logic [31:0] pc, input logic upd, input logic [3:0] ui,
                      input logic res, input logic prd, input logic clr);
    @(negedge clk);
    lookup_pc_i = pc; update_i = upd; update_idx_i = ui;
    result_i = res; predicted_i = prd; clear_i = clr;
    #1 check_outs();
    @(posedge clk);
    model_edge();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b0; update_i = 1'b0; clear_i = 1'b0;
    #1 m_reset();
    check_outs();
    @(posedge clk);
    #1 rst_i = 1'b1;
  endtask

  task automatic idle(input int n, input logic [31:0] pc);
    for (int i = 0; i < n; i++) step(pc, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    do_reset();
    // Init sweep: ready low for 16 cycles, high in cycle 17.
    idle(17, 32'h0);
    for (int i = 0; i < 16; i++) step(32'(i * 4), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Saturation at idx 3.
    for (int i = 0; i < 5; i++) step(32'h0C, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(32'h0C, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    idle(1, 32'h0C);

    // Aliasing: 0x40 and 0x80 share idx 0, 0x44 is idx 1.
    step(32'h40, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    step(32'h44, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(1, 32'h80);
    idle(1, 32'h44);

    // Same-cycle lookup and update of idx 5: no bypass.
    step(32'h14, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    idle(1, 32'h14);

    // Statistics and clear.
    do_reset();
    idle(17, 32'h0);
    for (int i = 0; i < 10; i++) step(32'h0, 1'b1, 4'(i), 1'b1, (i < 3) ? 1'b0 : 1'b1, 1'b0);
    idle(1, 32'h0);
    chk("br10", branch_cnt_o, 32'd10);
    chk("mis3", mispred_cnt_o, 32'd3);
    step(32'h8, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1);  // clear drops this update
    for (int i = 0; i < 16; i++) step(32'h8, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(32'(i * 4), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Clear during init restarts the sweep; reset mid-sweep.
    step(32'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(5, 32'h0);
    step(32'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(8, 32'h0);
    do_reset();
    idle(17, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 59) == 0));
      if (i == 250) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
